// File: rtl/mult_seq.sv
// mult_seq: sequential shift-and-add multiplier for the MiniMIPS execute stage.
// A WIDTH x WIDTH multiply takes WIDTH add/shift steps and then shows a
// one-cycle done pulse with the full 2*WIDTH product on product_hi:product_lo.
// The product holds until the next done or until reset.
// Optional feature macro: MULT_SIGNED_EN. When it is defined, signed_op selects
// MULT (signed) or MULTU (unsigned). When it is undefined, every multiply is
// unsigned and no negation logic is built.
module mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    input  logic             signed_op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
`ifdef MULT_SIGNED_EN
    localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W   = (2*WIDTH)'(1);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
    logic [WIDTH-1:0] prod_lo_q, prod_lo_d;
`ifdef MULT_SIGNED_EN
    logic             neg_q, neg_d;
`else
    // signed_op has no effect in the unsigned-only build.
    logic             unused_signed_op;
    assign unused_signed_op = signed_op;
`endif

    // One add/shift step. The sum is WIDTH+1 bits wide so that the adder carry
    // moves into acc_hi's MSB on the shift and is never lost.
    logic [WIDTH:0]     step_sum;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [2*WIDTH-1:0] step_full;
    logic [2*WIDTH-1:0] final_prod;

    // Datapath for a single step: a conditional add, then a right shift of {sum, acc_lo}.
    always_comb begin
        step_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
        step_hi   = step_sum[WIDTH:1];
        step_lo   = {step_sum[0], acc_lo_q[WIDTH-1:1]};
        step_full = {step_hi, step_lo};
`ifdef MULT_SIGNED_EN
        final_prod = neg_q ? (~step_full + ONE_2W) : step_full;
`else
        final_prod = step_full;
`endif
    end

    // Operand latch values. In signed mode the magnitude of the most negative
    // value is 2^(WIDTH-1), and it fits in WIDTH bits as an unsigned value.
    logic [WIDTH-1:0] lat_mcand;
    logic [WIDTH-1:0] lat_mplier;
`ifdef MULT_SIGNED_EN
    logic             lat_neg;
`endif

    // Select raw operands or their magnitudes for the latch.
    always_comb begin
`ifdef MULT_SIGNED_EN
        lat_mcand  = (signed_op && multiplicand[WIDTH-1]) ? (~multiplicand + ONE_W) : multiplicand;
        lat_mplier = (signed_op && multiplier[WIDTH-1])   ? (~multiplier + ONE_W)   : multiplier;
        lat_neg    = signed_op & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
`else
        lat_mcand  = multiplicand;
        lat_mplier = multiplier;
`endif
    end

    // Next-state logic for the FSM and all registered outputs.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        prod_hi_d = prod_hi_q;
        prod_lo_d = prod_lo_q;
`ifdef MULT_SIGNED_EN
        neg_d     = neg_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                // start is accepted in IDLE and in DONE (back-to-back).
                if (start) begin
                    state_d  = S_RUN;
                    busy_d   = 1'b1;
                    mcand_d  = lat_mcand;
                    acc_hi_d = '0;
                    acc_lo_d = lat_mplier;
                    cnt_d    = '0;
`ifdef MULT_SIGNED_EN
                    neg_d    = lat_neg;
`endif
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            S_RUN: begin
                // start is ignored here, so operands cannot be resampled mid-run.
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d   = S_DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    prod_hi_d = final_prod[2*WIDTH-1:WIDTH];
                    prod_lo_d = final_prod[WIDTH-1:0];
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register. An asynchronous reset aborts a run immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            prod_hi_q <= '0;
            prod_lo_q <= '0;
`ifdef MULT_SIGNED_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            prod_hi_q <= prod_hi_d;
            prod_lo_q <= prod_lo_d;
`ifdef MULT_SIGNED_EN
            neg_q     <= neg_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign product_hi = prod_hi_q;
    assign product_lo = prod_lo_q;

endmodule

// File: tb/tb_mult_seq.sv
// Directed self-checking bench for mult_seq (WIDTH=32).
module tb_mult_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        signed_op;
    logic        busy;
    logic        done;
    logic [31:0] product_hi;
    logic [31:0] product_lo;

    int checks   = 0;
    int failures = 0;

    mult_seq #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .signed_op    (signed_op),
        .busy         (busy),
        .done         (done),
        .product_hi   (product_hi),
        .product_lo   (product_lo)
    );

    always #5 clk = ~clk;

    // Issue one start pulse and wait for done, with a bound. lat is the number
    // of rising edges after the start edge; busy_ok is cleared if busy ever drops before done.
    task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input logic sop,
                           output int lat, output bit busy_ok);
        @(negedge clk);
        start = 1'b1; multiplicand = a; multiplier = b; signed_op = sop;
        @(negedge clk);
        start = 1'b0;
        busy_ok = (busy === 1'b1) && (done === 1'b0);
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
            if (done !== 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0; signed_op = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (product_hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", product_hi); end
        checks++; if (product_lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", product_lo); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat; bit bok;
        do_mult(32'd3, 32'd5, 1'b0, lat, bok);
        checks++; if (lat !== 32) begin failures++; $display("FAIL basic_latency got=%0d exp=32", lat); end
        checks++; if (bok !== 1'b1) begin failures++; $display("FAIL basic_busy_window got=%b exp=1", bok); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done got=%b exp=0", busy); end
        checks++; if (product_hi !== 32'h0) begin failures++; $display("FAIL basic_hi got=%h exp=00000000", product_hi); end
        checks++; if (product_lo !== 32'hF) begin failures++; $display("FAIL basic_lo got=%h exp=0000000f", product_lo); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
        checks++; if (product_lo !== 32'hF) begin failures++; $display("FAIL basic_hold got=%h exp=0000000f", product_lo); end
    endtask

    task automatic test_carry();
        int lat; bit bok;
        do_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, bok);
        checks++; if (lat !== 32) begin failures++; $display("FAIL carry_latency got=%0d exp=32", lat); end
        checks++; if (product_hi !== 32'hFFFFFFFE) begin failures++; $display("FAIL carry_hi got=%h exp=fffffffe", product_hi); end
        checks++; if (product_lo !== 32'h00000001) begin failures++; $display("FAIL carry_lo got=%h exp=00000001", product_lo); end
    endtask

`ifdef MULT_SIGNED_EN
    task automatic test_signed();
        int lat; bit bok;
        do_mult(32'hFFFFFFFD, 32'd7, 1'b1, lat, bok);
        checks++; if (lat !== 32) begin failures++; $display("FAIL sgn_latency got=%0d exp=32", lat); end
        checks++; if (product_hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL sgn_neg_hi got=%h exp=ffffffff", product_hi); end
        checks++; if (product_lo !== 32'hFFFFFFEB) begin failures++; $display("FAIL sgn_neg_lo got=%h exp=ffffffeb", product_lo); end
        do_mult(32'h80000000, 32'h80000000, 1'b1, lat, bok);
        checks++; if (product_hi !== 32'h40000000) begin failures++; $display("FAIL sgn_min_hi got=%h exp=40000000", product_hi); end
        checks++; if (product_lo !== 32'h00000000) begin failures++; $display("FAIL sgn_min_lo got=%h exp=00000000", product_lo); end
        do_mult(32'hFFFFFFFD, 32'd7, 1'b0, lat, bok);
        checks++; if (product_hi !== 32'h00000006) begin failures++; $display("FAIL sgn_off_hi got=%h exp=00000006", product_hi); end
        checks++; if (product_lo !== 32'hFFFFFFEB) begin failures++; $display("FAIL sgn_off_lo got=%h exp=ffffffeb", product_lo); end
    endtask
`endif

    // A start during RUN is ignored. Then start is held in DONE for a back-to-back multiply.
    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        start = 1'b1; multiplicand = 32'd6; multiplier = 32'd7; signed_op = 1'b0;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (lat == 10) begin start = 1'b1; multiplicand = 32'd9; multiplier = 32'd9; end
            else start = 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        checks++; if (lat !== 32) begin failures++; $display("FAIL ign_latency got=%0d exp=32", lat); end
        checks++; if (product_lo !== 32'h2A) begin failures++; $display("FAIL ign_lo got=%h exp=0000002a", product_lo); end
        checks++; if (product_hi !== 32'h0) begin failures++; $display("FAIL ign_hi got=%h exp=00000000", product_hi); end
        // We are in the DONE cycle now: hold start high so the next edge accepts it.
        start = 1'b1; multiplicand = 32'd2; multiplier = 32'd2;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL b2b_restart got=busy%b/done%b exp=busy1/done0", busy, done); end
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
        checks++; if (lat !== 32) begin failures++; $display("FAIL b2b_latency got=%0d exp=32", lat); end
        checks++; if (product_lo !== 32'd4) begin failures++; $display("FAIL b2b_lo got=%h exp=00000004", product_lo); end
    endtask

    task automatic test_reset_mid();
        int lat; bit bok; bit saw_done;
        @(negedge clk);
        start = 1'b1; multiplicand = 32'h1234; multiplier = 32'h5678; signed_op = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_pre_busy got=%b exp=1", busy); end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
        checks++; if (product_hi !== 32'h0) begin failures++; $display("FAIL rst_hi got=%h exp=0", product_hi); end
        checks++; if (product_lo !== 32'h0) begin failures++; $display("FAIL rst_lo got=%h exp=0", product_lo); end
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin @(negedge clk); if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1; end
        checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL rst_no_done got=%b exp=0", saw_done); end
        do_mult(32'd1, 32'd1, 1'b0, lat, bok);
        checks++; if (lat !== 32) begin failures++; $display("FAIL rst_after_latency got=%0d exp=32", lat); end
        checks++; if (product_lo !== 32'd1) begin failures++; $display("FAIL rst_after_lo got=%h exp=00000001", product_lo); end
        checks++; if (product_hi !== 32'd0) begin failures++; $display("FAIL rst_after_hi got=%h exp=00000000", product_hi); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
`ifdef MULT_SIGNED_EN
        test_signed();
`endif
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
